// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, hopper status and eject handshake bundle for the coin-return engine
interface change_dispenser_if #(parameter int AMT_W = 7);
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             q_empty;
    logic             d_empty;
    logic             n_empty;
    logic             eject_ack;
    logic             eject_q;
    logic             eject_d;
    logic             eject_n;
    logic             busy;
    logic             done;
    logic             err;
    logic [AMT_W-1:0] remain;
    modport master (
        output start, amount, q_empty, d_empty, n_empty, eject_ack,
        input  eject_q, eject_d, eject_n, busy, done, err, remain
    );
    modport slave (
        input  start, amount, q_empty, d_empty, n_empty, eject_ack,
        output eject_q, eject_d, eject_n, busy, done, err, remain
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: greedy quarter/dime/nickel payout with level/ack ejects; CHG_TIMEOUT_EN adds an ack timeout
module change_dispenser #(
    parameter int AMT_W       = 7,
    parameter int TIMEOUT_CYC = 16
) (
    input logic               clk,
    input logic               reset,
    change_dispenser_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SELECT, EJECT, DONE, ERR} state_t;
    typedef enum logic [1:0] {C_Q, C_D, C_N} coin_t;
    state_t           state;
    coin_t            coin;
    logic             eq, ed, en, busy, done, err;
    logic [AMT_W-1:0] remain, val, left;
`ifdef CHG_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;
`endif
    assign bus.eject_q = eq;
    assign bus.eject_d = ed;
    assign bus.eject_n = en;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.err     = err;
    assign bus.remain  = remain;
    // value of the latched coin and the amount left once it is acknowledged
    always_comb begin
        val  = coin == C_Q ? AMT_W'(25) : coin == C_D ? AMT_W'(10) : AMT_W'(5);
        left = remain - val;
    end
    // payout sequencer; all outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            coin   <= C_N;
            eq     <= 1'b0;
            ed     <= 1'b0;
            en     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            remain <= '0;
`ifdef CHG_TIMEOUT_EN
            cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    busy <= 1'b1;
                    if (bus.amount % AMT_W'(5) != '0) begin
                        remain <= bus.amount;
                        err    <= 1'b1;
                        state  <= ERR;
                    end else if (bus.amount == '0) begin
                        remain <= '0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        remain <= bus.amount;
                        state  <= SELECT;
                    end
                end
                SELECT: begin
`ifdef CHG_TIMEOUT_EN
                    cnt <= '0;
`endif
                    if (remain >= AMT_W'(25) && !bus.q_empty) begin
                        coin  <= C_Q;
                        eq    <= 1'b1;
                        state <= EJECT;
                    end else if (remain >= AMT_W'(10) && !bus.d_empty) begin
                        coin  <= C_D;
                        ed    <= 1'b1;
                        state <= EJECT;
                    end else if (!bus.n_empty) begin
                        coin  <= C_N;
                        en    <= 1'b1;
                        state <= EJECT;
                    end else begin
                        err   <= 1'b1;
                        state <= ERR;
                    end
                end
                EJECT: if (bus.eject_ack) begin
                    eq     <= 1'b0;
                    ed     <= 1'b0;
                    en     <= 1'b0;
                    remain <= left;
                    if (left == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= SELECT;
                    end
                end
`ifdef CHG_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    eq    <= 1'b0;
                    ed    <= 1'b0;
                    en    <= 1'b0;
                    err   <= 1'b1;
                    state <= ERR;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`endif
                DONE: begin
                    busy   <= 1'b0;
                    remain <= '0;
                    state  <= IDLE;
                end
                ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed payout scenarios with hand-computed expectations
module tb_change_dispenser;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ej;
    int         nchk = 0;
    int         nerr = 0;
    int         hi;
    change_dispenser_if #(.AMT_W(7)) bus ();
    change_dispenser #(.AMT_W(7), .TIMEOUT_CYC(16)) dut (.clk(clk), .reset(reset), .bus(bus));
    assign ej = {bus.eject_q, bus.eject_d, bus.eject_n};
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.amount = '0;
        bus.q_empty = 1'b0;
        bus.d_empty = 1'b0;
        bus.n_empty = 1'b0;
        bus.eject_ack = 1'b1;
        tick;
        tick;
        chk("rst_ej", ej, 3'b000);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_remain", bus.remain, 0);
        reset = 1'b0;
        // 30c: quarter then nickel
        bus.amount = 7'd30;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("t30_sel_busy", bus.busy, 1);
        chk("t30_sel_ej", ej, 3'b000);
        chk("t30_sel_rem", bus.remain, 30);
        tick;
        chk("t30_q", ej, 3'b100);
        tick;
        chk("t30_gap", ej, 3'b000);
        chk("t30_rem5", bus.remain, 5);
        tick;
        chk("t30_n", ej, 3'b001);
        tick;
        chk("t30_done", bus.done, 1);
        chk("t30_err", bus.err, 0);
        chk("t30_rem0", bus.remain, 0);
        chk("t30_ej_off", ej, 3'b000);
        tick;
        chk("t30_idle_busy", bus.busy, 0);
        chk("t30_done_pulse", bus.done, 0);
        // 40c with quarters empty: four dimes
        bus.q_empty = 1'b1;
        bus.amount = 7'd40;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t40_d", ej, 3'b010);
            tick;
            chk("t40_gap", ej, 3'b000);
            chk("t40_rem", bus.remain, 30 - 10 * i);
        end
        chk("t40_done", bus.done, 1);
        tick;
        chk("t40_idle", bus.busy, 0);
        // 15c with dimes and nickels empty: error, nothing ejected
        bus.q_empty = 1'b0;
        bus.d_empty = 1'b1;
        bus.n_empty = 1'b1;
        bus.amount = 7'd15;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        chk("t15_err", bus.err, 1);
        chk("t15_ej", ej, 3'b000);
        chk("t15_rem", bus.remain, 15);
        tick;
        chk("t15_err_pulse", bus.err, 0);
        chk("t15_rem_hold", bus.remain, 15);
        bus.d_empty = 1'b0;
        bus.n_empty = 1'b0;
        // 12c is not a multiple of 5: immediate error
        bus.amount = 7'd12;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("t12_err", bus.err, 1);
        chk("t12_rem", bus.remain, 12);
        chk("t12_ej", ej, 3'b000);
        tick;
        chk("t12_idle", bus.busy, 0);
        // 0c: done at once
        bus.amount = 7'd0;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("t0_done", bus.done, 1);
        chk("t0_rem", bus.remain, 0);
        chk("t0_ej", ej, 3'b000);
        tick;
        // 35c with ack withheld, then reset mid-eject
        bus.eject_ack = 1'b0;
        bus.amount = 7'd35;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        chk("t35_q", ej, 3'b100);
        tick;
        chk("t35_q_hold", ej, 3'b100);
        chk("t35_rem_hold", bus.remain, 35);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t35_rst_ej", ej, 3'b000);
        chk("t35_rst_busy", bus.busy, 0);
        chk("t35_rst_done", bus.done, 0);
        chk("t35_rst_err", bus.err, 0);
        // fresh 35c completes quarter then dime
        bus.eject_ack = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        chk("t35b_q", ej, 3'b100);
        tick;
        chk("t35b_rem", bus.remain, 10);
        tick;
        chk("t35b_d", ej, 3'b010);
        tick;
        chk("t35b_done", bus.done, 1);
        chk("t35b_rem0", bus.remain, 0);
        tick;
        // 10c with ack never given
        bus.eject_ack = 1'b0;
        bus.amount = 7'd10;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        chk("t10_d", ej, 3'b010);
        hi = 1;
`ifdef CHG_TIMEOUT_EN
        repeat (16) begin
            tick;
            if (ej == 3'b010) hi++;
        end
        chk("t10_hold_cycles", hi, 16);
        chk("t10_timeout_err", bus.err, 1);
        chk("t10_timeout_rem", bus.remain, 10);
        chk("t10_timeout_ej", ej, 3'b000);
`else
        repeat (99) begin
            tick;
            if (ej == 3'b010) hi++;
        end
        chk("t10_hold_cycles", hi, 100);
        chk("t10_no_err", bus.err, 0);
        chk("t10_busy", bus.busy, 1);
`endif
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("end_idle", bus.busy, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
